interboard_tx_serializer: RTL and testbench

- Downstream of the game-control stage: consumes its move-protocol strobe (`ctrl_en`) and field bundle.
- Buffers each move in a small FIFO and ships it bit-serially to the peer board over a 4-phase req/ack link.
- Gives game control back-pressure visibility (`busy`, `fifo_count`) and a sticky overflow flag.

---
 rtl/interboard_tx_serializer_if.sv | 33 +++
 rtl/interboard_tx_serializer.sv | 139 +++++++++++++
 tb/tb_interboard_tx_serializer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interboard_tx_serializer_if.sv
// interboard_tx_serializer_if: move-field bundle from game control, the peer req/ack link,
// and the back-pressure status returned by the serializer.
interface interboard_tx_serializer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                        ctrl_en;
  logic [3:0]                  ctrl_msg_type;
  logic [4:0]                  ctrl_block_x;
  logic [2:0]                  ctrl_block_y;
  logic [5:0]                  ctrl_card;
  logic [2:0]                  ctrl_sel_len;
  logic                        ctrl_move_dir;
  logic                        inter_ack;
  logic                        inter_req;
  logic                        inter_data;
  logic                        busy;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Serializer side.
  modport master (
    input  ctrl_en, ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card,
           ctrl_sel_len, ctrl_move_dir, inter_ack,
    output inter_req, inter_data, busy, overflow, fifo_count
  );

  // Game control plus peer board side.
  modport slave (
    output ctrl_en, ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card,
           ctrl_sel_len, ctrl_move_dir, inter_ack,
    input  inter_req, inter_data, busy, overflow, fifo_count
  );
endinterface

// File: rtl/interboard_tx_serializer.sv
// interboard_tx_serializer: FIFO-buffered move messages shipped MSB first over a 4-phase req/ack link.
// Define INTERBOARD_PARITY_EN to append an even-parity bit to every frame.
module interboard_tx_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  interboard_tx_serializer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 22;
`ifdef INTERBOARD_PARITY_EN
  localparam int NB = WW + 1;
`else
  localparam int NB = WW;
`endif
  localparam logic [4:0]    LAST       = 5'(NB - 1);
  localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);
  localparam logic [3:0]    SETUP_LAST = 4'(SETUP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [NB-1:0] shift_q;
  logic [4:0]    bit_cnt_q;
  logic [3:0]    setup_cnt_q;
  logic          req_q, data_q, busy_q, overflow_q;
  logic          ack_meta_q, ack_s_q;
  logic [WW-1:0] word_in, head;
  logic          push, pop, drop, idle_d;

  assign word_in = {bus.ctrl_msg_type, bus.ctrl_block_x, bus.ctrl_block_y,
                    bus.ctrl_card, bus.ctrl_sel_len, bus.ctrl_move_dir};
  assign head    = mem[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a strobe is accepted even when full.
  always_comb begin
    pop     = (state_q == IDLE) && (count_q != '0);
    push    = bus.ctrl_en && ((count_q != FULL) || pop);
    drop    = bus.ctrl_en && !push;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
    idle_d  = ((state_q == IDLE) && !pop) ||
              ((state_q == REQ_LO) && !ack_s_q && (bit_cnt_q == LAST));
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= word_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      setup_cnt_q <= '0;
      req_q       <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      ack_meta_q <= bus.inter_ack;
      ack_s_q    <= ack_meta_q;
      count_q    <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)
        overflow_q <= 1'b1;
      busy_q <= !idle_d || (count_d != '0);

      case (state_q)
        IDLE: begin
          if (pop) begin
`ifdef INTERBOARD_PARITY_EN
            shift_q <= {head, ^head};
`else
            shift_q <= head;
`endif
            data_q      <= head[WW-1];
            bit_cnt_q   <= '0;
            setup_cnt_q <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt_q == SETUP_LAST) begin
            req_q   <= 1'b1;
            state_q <= REQ_HI;
          end else begin
            setup_cnt_q <= setup_cnt_q + 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s_q) begin
            req_q   <= 1'b0;
            state_q <= REQ_LO;
          end
        end
        REQ_LO: begin
          // inter_data may only move once the peer has released ack.
          if (!ack_s_q) begin
            if (bit_cnt_q == LAST) begin
              state_q <= IDLE;
            end else begin
              shift_q     <= shift_q << 1;
              data_q      <= shift_q[NB-2];
              bit_cnt_q   <= bit_cnt_q + 1'b1;
              setup_cnt_q <= '0;
              state_q     <= SETUP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inter_req  = req_q;
  assign bus.inter_data = data_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_interboard_tx_serializer.sv
// tb_interboard_tx_serializer: directed and randomized moves against a word-level model,
// with a behavioural peer that acks after random delays and records every bit.
`timescale 1ns/1ps
module tb_interboard_tx_serializer;
  localparam int FIFO_DEPTH = 4;
  localparam int SETUP_CYC  = 1;
`ifdef INTERBOARD_PARITY_EN
  localparam int FB = 23;
`else
  localparam int FB = 22;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interboard_tx_serializer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  interboard_tx_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYC(SETUP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          rx_bits[$];
  int          rx_total  = 0;
  int          req_rises = 0;
  bit          peer_en   = 1'b1;
  int          min_dly   = 0;
  int          max_dly   = 0;
  int          hold_at   = -1;
  bit          mon_en    = 1'b0;
  logic        acks_m1, acks_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame value from the field rules: fields concatenated MSB first, optional even parity appended.
  function automatic logic [31:0] frame_of(input logic [3:0] t, input logic [4:0] x,
                                           input logic [2:0] y, input logic [5:0] c,
                                           input logic [2:0] s, input logic d);
    int w;
    w = int'(t) * 262144 + int'(x) * 8192 + int'(y) * 1024 + int'(c) * 16 + int'(s) * 2 + int'(d);
`ifdef INTERBOARD_PARITY_EN
    w = w * 2 + ($countones(w) % 2);
`endif
    return w;
  endfunction

  task automatic send(input logic [3:0] t, input logic [4:0] x, input logic [2:0] y,
                      input logic [5:0] c, input logic [2:0] s, input logic d, input bit keep);
    @(negedge clk);
    bus.ctrl_msg_type = t;
    bus.ctrl_block_x  = x;
    bus.ctrl_block_y  = y;
    bus.ctrl_card     = c;
    bus.ctrl_sel_len  = s;
    bus.ctrl_move_dir = d;
    bus.ctrl_en       = 1'b1;
    if (keep)
      exp_q.push_back(frame_of(t, x, y, c, s, d));
    @(negedge clk);
    bus.ctrl_en = 1'b0;
  endtask

  task automatic send_rand(input bit keep);
    send(4'($urandom_range(8, 0)), 5'($urandom), 3'($urandom), 6'($urandom),
         3'($urandom), 1'($urandom), keep);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (rx_bits.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("bits_arrived", 32'(rx_bits.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("busy_low", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] w = '0;
    checks++;
    assert (rx_bits.size() >= FB && exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s observed bits=%0d queued=%0d expected a full frame", tag, rx_bits.size(), exp_q.size());
      return;
    end
    for (int i = 0; i < FB; i++)
      w = {w[30:0], 1'(rx_bits.pop_front())};
    chk(tag, w, exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_bits.delete();
    exp_q.delete();
    rx_total = 0;
  endtask

  // Reference copy of the two-stage ack synchroniser, used to judge data stability.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acks_m1 <= 1'b0;
      acks_m  <= 1'b0;
    end else begin
      acks_m1 <= bus.inter_ack;
      acks_m  <= acks_m1;
    end
  end

  // Peer board: raise ack after a random delay, record the bit, drop ack after req falls.
  initial begin : peer
    int cnt;
    int dly;
    cnt = 0;
    dly = 0;
    bus.inter_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!peer_en) begin
        cnt = 0;
      end else if (bus.inter_req === 1'b1 && !bus.inter_ack) begin
        if (cnt >= dly) begin
          bus.inter_ack = 1'b1;
          rx_bits.push_back(bus.inter_data);
          rx_total++;
          cnt = 0;
          dly = int'($urandom_range(max_dly, min_dly));
        end else begin
          cnt++;
        end
      end else if (bus.inter_req === 1'b0 && bus.inter_ack && rx_total != hold_at) begin
        if (cnt >= dly) begin
          bus.inter_ack = 1'b0;
          cnt = 0;
          dly = int'($urandom_range(max_dly, min_dly));
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Count req pulses; inter_data may change only while req and the synchronised ack are both low.
  initial begin : monitor
    logic pr, pd, pa;
    pr = 1'b0;
    pd = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.inter_req === 1'b1 && !pr)
        req_rises++;
      if (mon_en && bus.inter_data !== pd) begin
        checks++;
        assert (!(pr || pa || bus.inter_req || acks_m)) else begin
          errors++;
          $error("FAIL data_stable observed data change with req=%0b ack_s=%0b expected req=0 ack_s=0",
                 bus.inter_req, acks_m);
        end
      end
      pr = bus.inter_req;
      pd = bus.inter_data;
      pa = acks_m;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog observed no completion expected $finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    bus.ctrl_en       = 1'b0;
    bus.ctrl_msg_type = '0;
    bus.ctrl_block_x  = '0;
    bus.ctrl_block_y  = '0;
    bus.ctrl_card     = '0;
    bus.ctrl_sel_len  = '0;
    bus.ctrl_move_dir = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req",      32'(bus.inter_req),  32'd0);
    chk("rst_data",     32'(bus.inter_data), 32'd0);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_overflow", 32'(bus.overflow),   32'd0);
    chk("rst_count",    32'(bus.fifo_count), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single frame, peer acks two cycles after req.
    min_dly   = 2;
    max_dly   = 2;
    req_rises = 0;
    send(4'd1, 5'd5, 3'd2, 6'h2A, 3'd3, 1'b1, 1'b1);
    chk("t1_count_after_push", 32'(bus.fifo_count), 32'd1);
    chk("t1_busy_after_push",  32'(bus.busy),       32'd1);
    wait_bits(FB, 3000);
    @(negedge clk);
    chk("t1_busy_in_frame", 32'(bus.busy), 32'd1);
    wait_idle(200);
    chk("t1_req_pulses", 32'(req_rises), 32'(FB));
    check_frame("t1_frame");

    // Same move with card 0x2B (flips the parity bit when enabled).
    min_dly = 0;
    max_dly = 7;
    send(4'd1, 5'd5, 3'd2, 6'h2B, 3'd3, 1'b1, 1'b1);
    wait_bits(FB, 3000);
    wait_idle(200);
    check_frame("t1b_frame");

    // Overflow: stalled peer, first move in flight, four buffered, sixth dropped.
    peer_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_rand(i < 5);
      repeat (3) @(negedge clk);
      chk($sformatf("t2_count_%0d", i), 32'(bus.fifo_count), 32'((i < FIFO_DEPTH) ? i : FIFO_DEPTH));
      chk($sformatf("t2_overflow_%0d", i), 32'(bus.overflow), 32'(i == 5));
    end
    chk("t2_busy_stalled", 32'(bus.busy), 32'd1);
    peer_en = 1'b1;
    wait_bits(5 * FB, 15000);
    wait_idle(400);
    for (int i = 0; i < 5; i++)
      check_frame($sformatf("t2_frame_%0d", i));
    chk("t2_no_extra_bits", 32'(rx_bits.size()), 32'd0);
    chk("t2_overflow_sticky", 32'(bus.overflow), 32'd1);
    do_reset();
    chk("t2_overflow_cleared", 32'(bus.overflow), 32'd0);

    // Simultaneous push and pop while full.
    hold_at = FB;
    for (int i = 0; i < 5; i++)
      send_rand(1'b1);
    chk("t3_count_full", 32'(bus.fifo_count), 32'd4);
    k = 0;
    while (!(rx_total == FB && bus.inter_req === 1'b0 && bus.inter_ack) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("t3_last_bit_held", 32'(rx_total == FB && bus.inter_req === 1'b0), 32'd1);
    bus.inter_ack = 1'b0;
    hold_at       = -1;
    repeat (3) @(posedge clk);
    send_rand(1'b1);
    chk("t3_count_same", 32'(bus.fifo_count), 32'd4);
    chk("t3_no_overflow", 32'(bus.overflow), 32'd0);
    wait_bits(6 * FB, 20000);
    wait_idle(400);
    for (int i = 0; i < 6; i++)
      check_frame($sformatf("t3_frame_%0d", i));

    // Reset in the middle of bit 10.
    send_rand(1'b1);
    k = 0;
    while (rx_total < 11 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("t4_req_async",   32'(bus.inter_req),  32'd0);
    chk("t4_count_async", 32'(bus.fifo_count), 32'd0);
    chk("t4_busy_async",  32'(bus.busy),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_bits.delete();
    exp_q.delete();
    rx_total = 0;
    repeat (20) @(negedge clk);
    rx_bits.delete();
    mon_en = 1'b1;
    send_rand(1'b1);
    wait_bits(FB, 3000);
    wait_idle(200);
    check_frame("t4_frame_after_reset");
    chk("t4_exact_length", 32'(rx_bits.size()), 32'd0);

    // Randomised moves and ack delays.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++)
        send_rand(1'b1);
      wait_bits(3 * FB, 6000);
      wait_idle(400);
      for (int i = 0; i < 3; i++)
        check_frame($sformatf("t5_r%0d_f%0d", r, i));
      chk($sformatf("t5_r%0d_overflow", r), 32'(bus.overflow), 32'd0);
      chk($sformatf("t5_r%0d_count", r), 32'(bus.fifo_count), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
